// File: rtl/holy_axi_lite_master_if.sv
// AXI-lite bus bundle (AW, W, B, AR, R) shared by the master and any slave.
// The byte-strobe width follows the data width.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/holy_axi_lite_master.sv
// Single-outstanding AXI-lite master. A simple valid/ready request port is
// turned into one AXI-lite read or write; completion is reported with a
// one-cycle rsp_valid pulse carrying read data and an error flag.
module holy_axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  axi_lite_if.master              m_axi_lite
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    DONE         = 3'd5
  } state_t;

  state_t                state_q;
  state_t                state_d;

  // Sticky per-channel completion flags for the write address/data phase
  logic                  aw_done_q;
  logic                  aw_done_d;
  logic                  w_done_q;
  logic                  w_done_d;

  // Request captured at acceptance; drives the AXI payload for the whole
  // transaction so later changes on req_* are ignored
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  // Completion results shown on the response port in DONE
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // Channel valid/ready outputs, decoded from registered state only so they
  // never depend combinationally on a ready from the slave
  logic                  awvalid;
  logic                  wvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  rready;

  logic                  req_hs;
  logic                  b_hs;
  logic                  r_hs;
  logic                  b_err;
  logic                  r_err;

  assign req_hs = req_valid && req_ready;
  assign b_hs   = bready && m_axi_lite.bvalid;
  assign r_hs   = rready && m_axi_lite.rvalid;

  // SLVERR (10) and DECERR (11) are errors; OKAY and EXOKAY are not
  assign b_err  = (m_axi_lite.bresp == 2'b10) || (m_axi_lite.bresp == 2'b11);
  assign r_err  = (m_axi_lite.rresp == 2'b10) || (m_axi_lite.rresp == 2'b11);

  // State and write-phase tracking flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state decode and per-state handshake outputs
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_valid) begin
          state_d = req_we ? WR_ADDR_DATA : RD_ADDR;
        end
      end

      WR_ADDR_DATA: begin
        // Each channel keeps its valid up until its own handshake; the
        // flags let AW and W finish in either order or together
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q || (awvalid && m_axi_lite.awready);
        w_done_d  = w_done_q  || (wvalid  && m_axi_lite.wready);
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      WR_RESP: begin
        bready = 1'b1;
        if (m_axi_lite.bvalid) begin
          state_d = DONE;
        end
      end

      RD_ADDR: begin
        arvalid = 1'b1;
        if (m_axi_lite.arready) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        rready = 1'b1;
        if (m_axi_lite.rvalid) begin
          state_d = DONE;
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        // Unreachable encodings fall back to IDLE on the next clock
        state_d   = IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // Request latch at acceptance and response capture on B/R handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_hs) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if ((state_q == WR_RESP) && b_hs) begin
        err_q <= b_err;
      end
      if ((state_q == RD_DATA) && r_hs) begin
        rdata_q <= m_axi_lite.rdata;
        err_q   <= r_err;
      end
    end
  end

  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.awvalid = awvalid;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wstrb_q;
  assign m_axi_lite.wvalid  = wvalid;
  assign m_axi_lite.bready  = bready;
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.arvalid = arvalid;
  assign m_axi_lite.rready  = rready;

  // A write completion never carries read data
  assign rsp_rdata = we_q ? '0 : rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_holy_axi_lite_master.sv
// Directed bench for holy_axi_lite_master with a small configurable
// AXI-lite slave model (per-channel wait states and response codes).
module tb_holy_axi_lite_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  holy_axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .m_axi_lite (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the stimulus only)
  int          cfg_aw_wait = 0;
  int          cfg_w_wait  = 0;
  int          cfg_ar_wait = 0;
  int          cfg_r_wait  = 0;
  logic [1:0]  cfg_bresp   = 2'b00;
  logic [1:0]  cfg_rresp   = 2'b00;
  logic [31:0] cfg_rdata   = 32'h0;

  // Slave state and observation counters (written by the slave model only)
  int          cyc = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rsp_n = 0;
  int          aw_vc = 0, w_vc = 0, ar_vc = 0;
  logic [31:0] awaddr_seen = 0, araddr_seen = 0, wdata_seen = 0;
  logic [3:0]  wstrb_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: decisions made mid-cycle; a valid&&ready seen here is the
  // handshake that completes on the following rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    end else begin
      axi.bvalid = b_pend;
      axi.bresp  = b_pend ? cfg_bresp : 2'b00;
      if (axi.bvalid && axi.bready) begin
        b_n++; b_pend = 0; aw_got = 0; w_got = 0;
      end
      if (axi.awvalid) begin
        axi.awready = (aw_cnt == cfg_aw_wait); aw_cnt++; aw_vc++;
      end else begin
        axi.awready = 1'b0; aw_cnt = 0;
      end
      if (axi.awvalid && axi.awready) begin
        aw_n++; aw_got = 1; awaddr_seen = axi.awaddr;
      end
      if (axi.wvalid) begin
        axi.wready = (w_cnt == cfg_w_wait); w_cnt++; w_vc++;
      end else begin
        axi.wready = 1'b0; w_cnt = 0;
      end
      if (axi.wvalid && axi.wready) begin
        w_n++; w_got = 1; wdata_seen = axi.wdata; wstrb_seen = axi.wstrb;
      end
      if (aw_got && w_got) b_pend = 1;

      if (r_pend) begin
        axi.rvalid = (r_cnt >= cfg_r_wait); r_cnt++;
      end else begin
        axi.rvalid = 1'b0;
      end
      axi.rdata = axi.rvalid ? cfg_rdata : 32'h0;
      axi.rresp = axi.rvalid ? cfg_rresp : 2'b00;
      if (axi.rvalid && axi.rready) begin
        r_n++; r_pend = 0;
      end
      if (axi.arvalid) begin
        axi.arready = (ar_cnt == cfg_ar_wait); ar_cnt++; ar_vc++;
      end else begin
        axi.arready = 1'b0; ar_cnt = 0;
      end
      if (axi.arvalid && axi.arready) begin
        ar_n++; araddr_seen = axi.araddr; r_pend = 1; r_cnt = 0;
      end
      if (rsp_valid) rsp_n++;
    end
  end

  // Snapshots for per-transaction deltas
  int s_aw, s_w, s_b, s_ar, s_r, s_rsp, s_awvc, s_wvc, s_arvc;

  task automatic snap();
    s_aw = aw_n; s_w = w_n; s_b = b_n; s_ar = ar_n; s_r = r_n; s_rsp = rsp_n;
    s_awvc = aw_vc; s_wvc = w_vc; s_arvc = ar_vc;
  endtask

  // One request: present, wait for acceptance, scramble req_* afterwards,
  // wait for the completion pulse and return latency and response
  task automatic run_txn(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic er, output int lat);
    int t;
    int acc;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_accept_in_time"}, (t < 50), 1);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hDEAD_BEE0; req_wdata = 32'h1234_5678; req_wstrb = 4'h0;
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_rsp_in_time"}, (t < 200), 1);
    lat = cyc - acc;
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    int t;
    int a1, a2, r1, r2;
    logic [31:0] rd1;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    chk("rst_axi_readies", {axi.bready, axi.rready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", req_ready, 1);

    // Zero-wait read of 0x4 returning 0x3
    cfg_rdata = 32'h3; cfg_rresp = 2'b00;
    snap();
    run_txn("rd0", 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    chk("rd0_latency", lat, 3);
    chk("rd0_rdata", rd, 32'h3);
    chk("rd0_err", er, 0);
    chk("rd0_araddr", araddr_seen, 32'h4);
    chk("rd0_arvalid_cycles", ar_vc - s_arvc, 1);
    chk("rd0_rsp_pulses", rsp_n - s_rsp, 1);

    // Write 0x1F to 0x0, awready held off two cycles, wready immediate
    cfg_aw_wait = 2; cfg_w_wait = 0; cfg_bresp = 2'b00;
    snap();
    run_txn("wr0", 1'b1, 32'h0, 32'h1F, 4'hF, rd, er, lat);
    chk("wr0_wvalid_cycles", w_vc - s_wvc, 1);
    chk("wr0_awvalid_cycles", aw_vc - s_awvc, 3);
    chk("wr0_latency", lat, 5);
    chk("wr0_err", er, 0);
    chk("wr0_rdata", rd, 0);
    chk("wr0_awaddr", awaddr_seen, 32'h0);
    chk("wr0_wdata", wdata_seen, 32'h1F);
    chk("wr0_wstrb", wstrb_seen, 4'hF);
    chk("wr0_b_hs", b_n - s_b, 1);

    // W well ahead of AW; addr must come from the latch, not live req_addr
    cfg_aw_wait = 4; cfg_w_wait = 0;
    snap();
    run_txn("wr1", 1'b1, 32'h10, 32'hCAFE_0001, 4'h3, rd, er, lat);
    chk("wr1_aw_hs", aw_n - s_aw, 1);
    chk("wr1_w_hs", w_n - s_w, 1);
    chk("wr1_b_hs", b_n - s_b, 1);
    chk("wr1_rsp_pulses", rsp_n - s_rsp, 1);
    chk("wr1_latency", lat, 7);
    chk("wr1_awaddr", awaddr_seen, 32'h10);
    chk("wr1_wstrb", wstrb_seen, 4'h3);

    // AW ahead of W
    cfg_aw_wait = 0; cfg_w_wait = 2;
    snap();
    run_txn("wr2", 1'b1, 32'h14, 32'h0000_00AA, 4'h1, rd, er, lat);
    chk("wr2_awvalid_cycles", aw_vc - s_awvc, 1);
    chk("wr2_wvalid_cycles", w_vc - s_wvc, 3);
    chk("wr2_latency", lat, 5);
    chk("wr2_wdata", wdata_seen, 32'hAA);

    // Zero-wait write: AW and W in the same cycle, minimum latency
    cfg_aw_wait = 0; cfg_w_wait = 0;
    snap();
    run_txn("wr3", 1'b1, 32'h18, 32'h5, 4'hF, rd, er, lat);
    chk("wr3_latency", lat, 3);
    chk("wr3_aw_w_hs", (aw_n - s_aw) + (w_n - s_w), 2);

    // Error responses
    cfg_rdata = 32'hFFFF_FFFF; cfg_rresp = 2'b11;
    run_txn("rd_err", 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    chk("rd_err_err", er, 1);
    chk("rd_err_rdata", rd, 32'hFFFF_FFFF);
    cfg_bresp = 2'b10;
    run_txn("wr_err", 1'b1, 32'hC, 32'h7, 4'hF, rd, er, lat);
    chk("wr_err_err", er, 1);
    chk("wr_err_rdata", rd, 0);
    cfg_bresp = 2'b01;
    run_txn("wr_exok", 1'b1, 32'hC, 32'h7, 4'hF, rd, er, lat);
    chk("wr_exok_err", er, 0);
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;

    // Read with AR and R wait states
    cfg_ar_wait = 1; cfg_r_wait = 2; cfg_rdata = 32'h1357_9BDF;
    snap();
    run_txn("rd1", 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
    chk("rd1_latency", lat, 6);
    chk("rd1_arvalid_cycles", ar_vc - s_arvc, 2);
    chk("rd1_rdata", rd, 32'h1357_9BDF);
    chk("rd1_araddr", araddr_seen, 32'h24);
    cfg_ar_wait = 0; cfg_r_wait = 0;

    // Back-to-back with req_valid held: read 0x8 then write 0x20
    cfg_rdata = 32'h55;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h8; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    a1 = cyc;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5; req_wstrb = 4'h3;
    r1 = -100; rd1 = 32'h0; t = 0;
    while (!req_ready && t < 50) begin
      if (rsp_valid) begin r1 = cyc; rd1 = rsp_rdata; end
      @(negedge clk); t++;
    end
    a2 = cyc;
    chk("b2b_second_accept_in_time", (t < 50), 1);
    chk("b2b_rd_latency", r1 - a1, 3);
    chk("b2b_accept_after_done", a2 - r1, 1);
    chk("b2b_rd_rdata", rd1, 32'h55);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFF0;
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    r2 = cyc;
    chk("b2b_wr_latency", r2 - a2, 3);
    chk("b2b_wr_rdata", rsp_rdata, 0);
    @(negedge clk); @(negedge clk);
    chk("b2b_araddr", araddr_seen, 32'h8);
    chk("b2b_awaddr", awaddr_seen, 32'h20);
    chk("b2b_wdata", wdata_seen, 32'hA5);

    // Reset while waiting in RD_DATA
    cfg_r_wait = 100;
    snap();
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'hC; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!axi.rready && t < 50) begin @(negedge clk); t++; end
    chk("mid_rst_reached_rd_data", axi.rready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    chk("mid_rst_readies", {axi.bready, axi.rready}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cfg_r_wait = 0;
    @(posedge clk); #1;
    chk("mid_rst_req_ready", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_n - s_rsp, 0);

    // Recovery read after the abandoned transaction
    cfg_rdata = 32'h9;
    run_txn("rd_rec", 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("rd_rec_latency", lat, 3);
    chk("rd_rec_rdata", rd, 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
